hilo_unit: RTL and testbench



---
 rtl/hilo_unit.sv | 151 +++++++++++++++
 tb/tb_hilo_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair for the EX stage.
// Captures MULT products, services MTHI/MTLO, and runs a 32-iteration
// restoring divider for DIV/DIVU. HI/LO only change at an op's completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | accepting ops; single-cycle ops and divide-by-zero finish here
// S_DIVIDE | restoring divide in flight, one quotient bit per cycle

module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic [31:0] mul_lo,
    input  logic [31:0] mul_hi,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_DIVIDE = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic [5:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;

    // Step datapath and operand conditioning
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [32:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        x_neg;
    logic        y_neg;
    logic [31:0] x_mag;
    logic [31:0] y_mag;

    // One restoring iteration plus the final sign fix, and operand magnitudes
    always_comb begin
        rem_shift = {rem_q[31:0], quo_q[31]};
        // rem_q[32] set would mean the shifted value already exceeds any divisor
        rem_ge    = rem_q[32] | (rem_shift >= {1'b0, dvs_q});
        rem_d     = rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        quo_d     = {quo_q[30:0], rem_ge};
        quo_fix   = qneg_q ? (~quo_d + 32'd1) : quo_d;
        rem_fix   = rneg_q ? (~rem_d[31:0] + 32'd1) : rem_d[31:0];

        x_neg     = (op == OP_DIV) & X[31];
        y_neg     = (op == OP_DIV) & Y[31];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        x_mag     = x_neg ? (~X + 32'd1) : X;
        y_mag     = y_neg ? (~Y + 32'd1) : Y;
    end

    // Control FSM with all registered outputs and divider state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= 6'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid && !busy_q) begin
                        case (op)
                            OP_MULT: begin
                                hi_q <= mul_hi;
                                lo_q <= mul_lo;
                            end
                            OP_MTHI: hi_q <= X;
                            OP_MTLO: lo_q <= X;
                            OP_DIV, OP_DIVU: begin
                                if (Y == 32'd0) begin
                                    hi_q       <= X;
                                    lo_q       <= 32'hFFFF_FFFF;
                                    done_q     <= 1'b1;
                                    div_zero_q <= 1'b1;
                                end else begin
                                    quo_q   <= x_mag;
                                    dvs_q   <= y_mag;
                                    rem_q   <= 33'd0;
                                    qneg_q  <= x_neg ^ y_neg;
                                    rneg_q  <= x_neg;
                                    cnt_q   <= 6'd32;
                                    busy_q  <= 1'b1;
                                    state_q <= S_DIVIDE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_q    <= rem_fix;
                        lo_q    <= quo_fix;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the driver keeps an architectural model of
// HI/LO and the busy window and queues expectations; a negedge monitor
// compares whenever done pulses or a single-cycle result is due.

module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] X = 32'd0;
    logic [31:0] Y = 32'd0;
    logic [31:0] mul_lo = 32'd0;
    logic [31:0] mul_hi = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    hilo_unit dut (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .X(X), .Y(Y),
        .mul_lo(mul_lo), .mul_hi(mul_hi), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy_n;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
    } exp_t;

    exp_t        div_q[$];
    exp_t        reg_q[$];
    int          cyc = 0;
    int          busy_end = -1;
    int          busy_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic, truncating toward zero
    function automatic void ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r);
        longint a, b, qq, rr;
        if (sgn) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'({32'd0, x});
            b = longint'({32'd0, y});
        end
        qq = a / b;
        rr = a % b;
        q = qq[31:0];
        r = rr[31:0];
    endfunction

    task automatic push_reg();
        exp_t e;
        e.due = cyc + 1; e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0;
        e.busy_n = 0; e.hold_hi = m_hi; e.hold_lo = m_lo;
        reg_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] mh, input logic [31:0] ml);
        exp_t e;
        logic [31:0] q, r;
        @(posedge clk); #1;
        valid = 1'b1; op = o; X = x; Y = y; mul_hi = mh; mul_lo = ml;
        if (cyc > busy_end) begin
            case (o)
                3'd1: begin m_hi = mh; m_lo = ml; push_reg(); end
                3'd4: begin m_hi = x; push_reg(); end
                3'd5: begin m_lo = x; push_reg(); end
                3'd2, 3'd3: begin
                    e.hold_hi = m_hi; e.hold_lo = m_lo; e.due = 0;
                    if (y == 32'd0) begin
                        e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.busy_n = 0;
                    end else begin
                        ref_div(o == 3'd2, x, y, q, r);
                        e.hi = r; e.lo = q; e.dz = 1'b0; e.busy_n = 32;
                        busy_end = cyc + 32;
                    end
                    m_hi = e.hi; m_lo = e.lo;
                    div_q.push_back(e);
                end
                default: push_reg();
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; valid = 1'b0; end
    endtask

    // Leaves the next issue landing in the cycle right after the busy window
    task automatic wait_free();
        while (cyc + 1 <= busy_end) begin @(posedge clk); #1; valid = 1'b0; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; valid = 1'b0;
        div_q.delete();
        while (reg_q.size() > 0 && reg_q[reg_q.size()-1].due > cyc) void'(reg_q.pop_back());
        m_hi = 32'd0; m_lo = 32'd0; busy_end = -1;
        push_reg();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_x();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_y();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(1, 9));
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: done-driven divide checks, hold checks, and due single-cycle checks
    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_cnt = 0;
        else if (busy === 1'b1) busy_cnt++;
        if (!rst && busy === 1'b1 && div_q.size() > 0) begin
            chk("hold_hi", hi, div_q[0].hold_hi);
            chk("hold_lo", lo, div_q[0].hold_lo);
        end
        if (done === 1'b1) begin
            if (div_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = div_q.pop_front();
                chk("div_hi", hi, e.hi);
                chk("div_lo", lo, e.lo);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
            end
            busy_cnt = 0;
        end else if (div_zero === 1'b1) begin
            chk("div_zero_without_done", {31'd0, div_zero}, 32'd0);
        end
        while (reg_q.size() > 0 && reg_q[0].due <= cyc) begin
            e = reg_q.pop_front();
            chk("reg_hi", hi, e.hi);
            chk("reg_lo", lo, e.lo);
            chk("reg_busy", {31'd0, busy}, 32'd0);
            chk("reg_done", {31'd0, done}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] o;
        int gap;
        do_reset();
        issue(3'd1, 32'd0, 32'd0, 32'h0000_0001, 32'h2345_6789);
        idle(1);
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);                   wait_free();
        issue(3'd3, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'd0);             wait_free();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);              wait_free();
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0);              wait_free();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);      wait_free();
        issue(3'd3, 32'd5, 32'd0, 32'd0, 32'd0);
        idle(2);
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
        idle(3);
        issue(3'd4, 32'h0000_DEAD, 32'd0, 32'd0, 32'd0);
        wait_free();
        issue(3'd5, 32'd9, 32'd0, 32'd0, 32'd0);
        idle(1);
        issue(3'd3, 32'd12345, 32'd11, 32'd0, 32'd0);
        idle(8);
        do_reset();
        issue(3'd3, 32'd9, 32'd4, 32'd0, 32'd0);
        wait_free();
        idle(1);
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            issue(o, rand_x(), rand_y(), $urandom, $urandom);
            gap = $urandom_range(0, 3);
            if (gap == 3) wait_free();
            else idle(gap);
        end
        wait_free();
        idle(3);
        chk("queues_drained", 32'(div_q.size() + reg_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
